// File: rtl/axis_packet_arbiter.sv
// rtl/axis_packet_arbiter.sv - two-source AXI-Stream packet arbiter with round-robin grant and beat limit
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   src_enable[1:0]             per-source gate on new grants (bit n -> source n)
//   s0_axis_*                   source 0 stream (tone generator)
//   s1_axis_*                   source 1 stream (DMA stream)
//   m_axis_*                    arbitrated output stream (audio sink)
//   grant[1:0]                  registered one-hot grant, 2'b00 while idle
module axis_packet_arbiter #(
  parameter int AXIS_DATA_WIDTH  = 32,
  parameter int AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH / 8,
  parameter int MAX_PACKET_BEATS = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 src_enable,

  input  logic [AXIS_DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s0_axis_tkeep,
  input  logic                       s0_axis_tvalid,
  input  logic                       s0_axis_tlast,
  output logic                       s0_axis_tready,

  input  logic [AXIS_DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s1_axis_tkeep,
  input  logic                       s1_axis_tvalid,
  input  logic                       s1_axis_tlast,
  output logic                       s1_axis_tready,

  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready,

  output logic [1:0]                 grant
);

  // State encoding doubles as the one-hot grant vector.
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] GRANT0 = 2'b01;
  localparam logic [1:0] GRANT1 = 2'b10;

  localparam logic [15:0] LAST_BEAT = 16'(MAX_PACKET_BEATS - 1);

  logic [1:0]  state;
  logic        last_grant;
  logic [15:0] beat_cnt;
  logic        req0;
  logic        req1;
  logic        limit_hit;
  logic        beat;

  assign req0      = s0_axis_tvalid & src_enable[0];
  assign req1      = s1_axis_tvalid & src_enable[1];
  assign limit_hit = (beat_cnt == LAST_BEAT);
  assign grant     = state;
  assign beat      = m_axis_tvalid & m_axis_tready;

  // Pure mux: nothing is buffered, so valid/data follow the granted source
  // and the granted source's ready follows the sink.
  always_comb begin
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    case (state)
      GRANT0: begin
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tkeep   = s0_axis_tkeep;
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tlast   = s0_axis_tlast | limit_hit;
        s0_axis_tready = m_axis_tready;
      end
      GRANT1: begin
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tkeep   = s1_axis_tkeep;
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tlast   = s1_axis_tlast | limit_hit;
        s1_axis_tready = m_axis_tready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;  // source 0 wins the first contention
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (req0 && req1) begin
            state <= last_grant ? GRANT0 : GRANT1;
          end else if (req0) begin
            state <= GRANT0;
          end else if (req1) begin
            state <= GRANT1;
          end
        end
        GRANT0, GRANT1: begin
          // A forced tlast ends the grant just like a source tlast; the
          // source resumes the rest of its packet in a later grant.
          if (beat) begin
            if (m_axis_tlast) begin
              state      <= IDLE;
              last_grant <= state[1];
              beat_cnt   <= '0;
            end else begin
              beat_cnt <= beat_cnt + 16'd1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb/tb_axis_packet_arbiter.sv - scoreboard bench for axis_packet_arbiter
module tb_axis_packet_arbiter;
  localparam int DW   = 32;
  localparam int KW   = 4;
  localparam int MAXB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    src_enable;
  logic [DW-1:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
  logic [KW-1:0] s0_axis_tkeep, s1_axis_tkeep, m_axis_tkeep;
  logic          s0_axis_tvalid, s0_axis_tlast, s0_axis_tready;
  logic          s1_axis_tvalid, s1_axis_tlast, s1_axis_tready;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [1:0]    grant;

  axis_packet_arbiter #(
    .AXIS_DATA_WIDTH (DW),
    .AXIS_KEEP_WIDTH (KW),
    .MAX_PACKET_BEATS(MAXB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .src_enable    (src_enable),
    .s0_axis_tdata (s0_axis_tdata),
    .s0_axis_tkeep (s0_axis_tkeep),
    .s0_axis_tvalid(s0_axis_tvalid),
    .s0_axis_tlast (s0_axis_tlast),
    .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata (s1_axis_tdata),
    .s1_axis_tkeep (s1_axis_tkeep),
    .s1_axis_tvalid(s1_axis_tvalid),
    .s1_axis_tlast (s1_axis_tlast),
    .s1_axis_tready(s1_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .grant         (grant)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [1:0]    grant;
  } exp_t;

  beat_t q0[$];
  beat_t q1[$];
  exp_t  expq[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    beats_seen  = 0;
  logic  f0, f1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic beat_t mk(input int src, input int tag, input int k, input bit last);
    beat_t b;
    b.data = 32'hD000_0000 | (32'(src) << 16) | (32'(tag) << 8) | 32'(k);
    b.keep = 4'(15 - (k % 4));
    b.last = last;
    return b;
  endfunction

  task automatic send(input int src, input int tag, input int n, input bit last_at_end);
    for (int k = 0; k < n; k++) begin
      if (src == 0) q0.push_back(mk(src, tag, k, last_at_end && (k == n - 1)));
      else          q1.push_back(mk(src, tag, k, last_at_end && (k == n - 1)));
    end
  endtask

  task automatic expect_beat(input int src, input int tag, input int k, input bit last);
    beat_t b;
    exp_t  e;
    b       = mk(src, tag, k, last);
    e.data  = b.data;
    e.keep  = b.keep;
    e.last  = last;
    e.grant = (src == 0) ? 2'b01 : 2'b10;
    expq.push_back(e);
  endtask

  task automatic expect_pkt(input int src, input int tag, input int n);
    for (int k = 0; k < n; k++) expect_beat(src, tag, k, k == n - 1);
  endtask

  // Test actions land at negedge+1; driver and monitor sample at negedge+3.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Source models: present queue heads, pop on accepted beats.
  always begin
    @(negedge clk);
    #3;
    f0 = !reset && s0_axis_tvalid && s0_axis_tready;
    f1 = !reset && s1_axis_tvalid && s1_axis_tready;
    @(posedge clk);
    #1;
    if (f0 && q0.size() > 0) void'(q0.pop_front());
    if (f1 && q1.size() > 0) void'(q1.pop_front());
    s0_axis_tvalid = q0.size() > 0;
    s0_axis_tdata  = (q0.size() > 0) ? q0[0].data : '0;
    s0_axis_tkeep  = (q0.size() > 0) ? q0[0].keep : '0;
    s0_axis_tlast  = (q0.size() > 0) ? q0[0].last : 1'b0;
    s1_axis_tvalid = q1.size() > 0;
    s1_axis_tdata  = (q1.size() > 0) ? q1[0].data : '0;
    s1_axis_tkeep  = (q1.size() > 0) ? q1[0].keep : '0;
    s1_axis_tlast  = (q1.size() > 0) ? q1[0].last : 1'b0;
  end

  // Monitor: every output beat must match the head of the expected queue.
  always begin
    exp_t e;
    @(negedge clk);
    #3;
    if (!reset && m_axis_tvalid && m_axis_tready) begin
      beats_seen++;
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_unexpected: got beat data %0h grant %0b, expected no beat", m_axis_tdata, grant);
      end else begin
        e = expq.pop_front();
        check("sb_data",  64'(m_axis_tdata), 64'(e.data));
        check("sb_keep",  64'(m_axis_tkeep), 64'(e.keep));
        check("sb_last",  64'(m_axis_tlast), 64'(e.last));
        check("sb_grant", 64'(grant),        64'(e.grant));
      end
    end
  end

  task automatic drain(input string name);
    int t = 0;
    while ((expq.size() > 0 || q0.size() > 0 || q1.size() > 0) && t < 200) begin
      tick();
      t++;
    end
    check({name, "_drain"}, 64'(expq.size() + q0.size() + q1.size()), 64'd0);
    tick();
    tick();
  endtask

  task automatic wait_beats(input string name, input int n);
    int target = beats_seen + n;
    int t = 0;
    while (beats_seen < target && t < 100) begin
      tick();
      t++;
    end
    check({name, "_wait"}, 64'(beats_seen >= target), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_g;
    reset = 1'b1;
    src_enable = 2'b00;
    m_axis_tready = 1'b1;
    s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tkeep = '0; s0_axis_tlast = 1'b0;
    s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tkeep = '0; s1_axis_tlast = 1'b0;
    repeat (3) tick();
    check("rst_grant",   64'(grant),          64'd0);
    check("rst_mvalid",  64'(m_axis_tvalid),  64'd0);
    check("rst_s0ready", 64'(s0_axis_tready), 64'd0);
    check("rst_s1ready", 64'(s1_axis_tready), 64'd0);
    check("rst_mdata",   64'(m_axis_tdata),   64'd0);
    check("rst_mkeep",   64'(m_axis_tkeep),   64'd0);
    check("rst_mlast",   64'(m_axis_tlast),   64'd0);
    reset = 1'b0;
    tick();

    // Round robin with 4-beat packets from both sources.
    src_enable = 2'b11;
    send(0, 1, 4, 1); send(0, 3, 4, 1);
    send(1, 2, 4, 1); send(1, 4, 4, 1);
    expect_pkt(0, 1, 4); expect_pkt(1, 2, 4); expect_pkt(0, 3, 4); expect_pkt(1, 4, 4);
    for (int i = 0; i < 18; i++) begin
      tick();
      if (i == 0 || i == 5 || i == 10 || i == 15) exp_g = 2'b00;
      else if (i < 5 || (i > 10 && i < 15))      exp_g = 2'b01;
      else                                        exp_g = 2'b10;
      check("rr_grant", 64'(grant), 64'(exp_g));
    end
    drain("rr");

    // Beat limit: no source tlast, forced tlast every MAXB beats.
    src_enable = 2'b01;
    send(0, 5, 16, 0);
    for (int k = 0; k < 16; k++) expect_beat(0, 5, k, (k == MAXB - 1) || (k == 2 * MAXB - 1));
    drain("limit");

    // Sink backpressure toggling during a GRANT1 packet.
    src_enable = 2'b11;
    send(1, 0, 4, 1);
    expect_pkt(1, 0, 4);
    for (int i = 0; i < 12; i++) begin
      tick();
      m_axis_tready = (i % 2 == 0);
      #1;
      if (grant == 2'b10) begin
        check("bp_s1ready", 64'(s1_axis_tready), 64'(m_axis_tready));
        check("bp_s0ready", 64'(s0_axis_tready), 64'd0);
      end
    end
    m_axis_tready = 1'b1;
    drain("bp");

    // Disable source 0 mid-packet: packet completes, no regrant while disabled.
    src_enable = 2'b11;
    send(0, 6, 4, 1); send(1, 7, 4, 1);
    expect_pkt(0, 6, 4); expect_pkt(1, 7, 4);
    wait_beats("dis", 2);
    src_enable = 2'b10;
    drain("dis");
    send(0, 8, 2, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("dis_noregrant", 64'(grant == 2'b01), 64'd0);
    end
    expect_pkt(0, 8, 2);
    src_enable = 2'b11;
    drain("reen");

    // Reset on beat 3 of a GRANT1 packet; s0 wins first post-reset contention.
    send(1, 9, 6, 1); send(0, 10, 2, 1);
    expect_beat(1, 9, 0, 0); expect_beat(1, 9, 1, 0);
    wait_beats("rst", 2);
    reset = 1'b1;
    tick();
    check("midrst_grant",   64'(grant),          64'd0);
    check("midrst_mvalid",  64'(m_axis_tvalid),  64'd0);
    check("midrst_s0ready", 64'(s0_axis_tready), 64'd0);
    check("midrst_s1ready", 64'(s1_axis_tready), 64'd0);
    q1.delete();
    send(1, 11, 1, 1);
    tick();
    reset = 1'b0;
    expect_pkt(0, 10, 2); expect_pkt(1, 11, 1);
    tick();
    check("postrst_grant", 64'(grant), 64'h1);
    drain("postrst");

    // Single-beat packets: strict alternation with IDLE between grants.
    for (int k = 0; k < 4; k++) begin
      send(0, 12, 1, 1); send(1, 13, 1, 1);
      expect_pkt(0, 12, 1); expect_pkt(1, 13, 1);
    end
    for (int i = 0; i < 17; i++) begin
      tick();
      if (i % 2 == 0)      exp_g = 2'b00;
      else if (i % 4 == 1) exp_g = 2'b01;
      else                 exp_g = 2'b10;
      check("single_grant",  64'(grant),         64'(exp_g));
      check("single_mvalid", 64'(m_axis_tvalid), 64'(i % 2 == 1));
    end
    drain("single");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axis_packet_arbiter.md
AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

Interface
REQ-001 Parameter AXIS_DATA_WIDTH, default 32: tdata width of all ports.
REQ-002 Parameter AXIS_KEEP_WIDTH, default AXIS_DATA_WIDTH/8: tkeep width of all ports.
REQ-003 Parameter MAX_PACKET_BEATS, default 256: beat limit per grant; legal range 2..65536.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 src_enable  in  2  per-source enable; bit n gates new grants to source n.
REQ-007 s0_axis_tdata / s0_axis_tkeep  in  AXIS_DATA_WIDTH / AXIS_KEEP_WIDTH  source 0 payload (tone generator).
REQ-008 s0_axis_tvalid, s0_axis_tlast  in  1 each; s0_axis_tready  out  1.
REQ-009 s1_axis_tdata / s1_axis_tkeep  in  AXIS_DATA_WIDTH / AXIS_KEEP_WIDTH  source 1 payload (DMA stream).
REQ-010 s1_axis_tvalid, s1_axis_tlast  in  1 each; s1_axis_tready  out  1.
REQ-011 m_axis_tdata / m_axis_tkeep  out  AXIS_DATA_WIDTH / AXIS_KEEP_WIDTH  arbitrated payload to audio sink.
REQ-012 m_axis_tvalid, m_axis_tlast  out  1 each; m_axis_tready  in  1.
REQ-013 grant  out  2  one-hot registered grant; 2'b00 when idle.

Function
REQ-014 FSM states IDLE, GRANT0, GRANT1, state held in registers.
REQ-015 Request n = sn_axis_tvalid & src_enable[n], sampled in IDLE only.
REQ-016 IDLE, no request: stay IDLE.
REQ-017 IDLE, one request: next state is GRANT of that source.
REQ-018 IDLE, both requesting: grant the source not in register last_grant (round robin).
REQ-019 Arbitration latency: exactly one IDLE cycle between grants; no beat transfers in IDLE.
REQ-020 In IDLE: m_axis_tvalid=0, s0/s1 tready=0, m_axis_tdata/tkeep/tlast=0, grant=2'b00.
REQ-021 In GRANTn: m_axis_tdata/tkeep/tvalid = sn values combinationally; sn_axis_tready = m_axis_tready; other source tready=0.
REQ-022 grant = 2'b01 in GRANT0 and 2'b10 in GRANT1.
REQ-023 Beat = m_axis_tvalid & m_axis_tready; 16-bit beat_cnt increments per beat in GRANTn and clears on leaving GRANTn.
REQ-024 m_axis_tlast = sn_axis_tlast | (beat_cnt == MAX_PACKET_BEATS-1) in GRANTn (forced tlast).
REQ-025 Beat with m_axis_tlast=1: next state IDLE, last_grant <= n.
REQ-026 Forced tlast ends the grant even if source tlast was 0; source continues its packet in a later grant.
REQ-027 src_enable[n] deasserting during GRANTn has no effect until the grant ends.
REQ-028 sn_axis_tvalid low during GRANTn: stall, hold state and beat_cnt, m_axis_tvalid=0.
REQ-029 m_axis_tready low: hold state and beat_cnt; no handshake on the granted source.
REQ-030 Output valid never depends on m_axis_tready; no data is buffered, duplicated or dropped.

Reset
REQ-031 reset=1 at a clock edge: state=IDLE, last_grant=1 (source 0 wins first contention), beat_cnt=0.
REQ-032 Outputs during and after reset until the first grant: as in REQ-020.
REQ-033 Reset mid-packet abandons the grant; m_axis_tvalid=0 from the cycle after the reset edge.

Verification
REQ-034 Both sources valid continuously, tready=1, tlast every 4 beats, enable=2'b11 -> grants alternate 01,00,10,00,01...; 4 beats per grant, s0 granted first.
REQ-035 s0 only (enable=2'b01), tlast never asserted, MAX_PACKET_BEATS=8 -> m_axis_tlast on beat 8; IDLE 1 cycle; regrant to s0; 8 beats again.
REQ-036 m_axis_tready toggles 1,0,1,0 during GRANT1 -> s1_axis_tready mirrors it; beat_cnt advances only on ready-high cycles; data order matches s1 sequence 0,1,2,3.
REQ-037 Clear src_enable[0] after beat 2 of a 4-beat s0 packet -> all 4 beats delivered, then s1 granted; s0 not regranted while disabled.
REQ-038 Assert reset on beat 3 of a GRANT1 packet -> next cycle grant=00, m_axis_tvalid=0, both tready=0; first post-reset contention grants s0.
REQ-039 Single-beat packets (tlast on every beat) from both sources -> one beat per grant, 50% output duty from IDLE cycles, strict alternation.
